// File: rtl/dma_host_bus_master_pkg.sv
// Shared configuration, host-side state encoding and the controller's
// register map as seen from the CPU side of the bus.
package dma_host_bus_master_pkg;

    localparam int DATAWIDTH = 8;
    localparam int CHANNELS  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RECOVER = 3'd3,
        GRANT   = 3'd4,
        HOLD    = 3'd5,
        TURN    = 3'd6
    } host_state_t;

    // Status (read) and command (write) share address 8.
    localparam logic [3:0] REG_STATUS       = 4'h8;
    localparam logic [3:0] REG_COMMAND      = 4'h8;
    localparam logic [3:0] REG_REQUEST      = 4'h9;
    localparam logic [3:0] REG_MASK         = 4'hA;
    localparam logic [3:0] REG_MODE         = 4'hB;
    localparam logic [3:0] REG_CLEAR_FF     = 4'hC;
    localparam logic [3:0] REG_MASTER_CLEAR = 4'hD;

    function automatic logic [3:0] ch_addr_reg(input logic [1:0] ch);
        return {1'b0, ch, 1'b0};
    endfunction

    function automatic logic [3:0] ch_count_reg(input logic [1:0] ch);
        return {1'b0, ch, 1'b1};
    endfunction

endpackage

// File: rtl/dma_host_bus_master_if.sv
// Command/response port between a CPU model and the host bus master.
interface dma_host_bus_master_if;
    import dma_host_bus_master_pkg::*;

    // A command transfers on a clock edge where cmd_valid & cmd_ready are both 1;
    // cmd_write/cmd_addr/cmd_wdata must be stable while cmd_valid is high.
    // rsp_valid is a one-cycle pulse with no back-pressure; rsp_rdata holds afterwards.
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [3:0]           cmd_addr;
    logic [DATAWIDTH-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic [DATAWIDTH-1:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dma_host_bus_master_hold_responder.sv
// Hold responder: answers HRQ with HLDA after a programmable delay and
// tells the top level when the bus lines must be released.
module dma_host_bus_master_hold_responder
    import dma_host_bus_master_pkg::*;
#(
    parameter int HLDA_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hrq,
    input  logic        start,
    output host_state_t state,
    output logic        active,
    output logic        hlda,
    output logic        bus_owned
);

    localparam int            CW   = (HLDA_DELAY > 1) ? $clog2(HLDA_DELAY) : 1;
    localparam logic [CW-1:0] LAST = CW'(HLDA_DELAY - 1);

    host_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // A request withdrawn before the delay expires never sees HLDA.
                if (!hrq)                state_d = IDLE;
                else if (cnt_q == LAST)  state_d = HOLD;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            HOLD:    if (!hrq) state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign state     = state_q;
    assign active    = (state_q != IDLE);
    assign hlda      = (state_q == HOLD);
    assign bus_owned = !((state_q == HOLD) || (state_q == TURN));

endmodule

// File: rtl/dma_host_bus_master.sv
// CPU-style I/O cycle generator into the DMA controller's register file,
// with hold handover to the controller via the hold responder.
module dma_host_bus_master
    import dma_host_bus_master_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int HLDA_DELAY    = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    dma_host_bus_master_if.slave  cmd,
    input  logic                  HRQ,
    output logic                  HLDA,
    output logic                  CS_N,
    inout  wire                   IOR_N,
    inout  wire                   IOW_N,
    inout  wire                   A0,
    inout  wire                   A1,
    inout  wire                   A2,
    inout  wire                   A3,
    inout  wire  [DATAWIDTH-1:0]  DB,
    output host_state_t           state
);

    localparam int             SCW    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SCW-1:0] S_LAST = SCW'(STROBE_CYCLES - 1);

    host_state_t          cyc_q, cyc_d;
    logic [SCW-1:0]       scnt_q, scnt_d;
    logic [3:0]           addr_q, addr_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;

    host_state_t hr_state;
    logic        hr_active;
    logic        bus_owned;
    logic        ready;
    logic        in_cycle;
    logic        ior_n_int;
    logic        iow_n_int;

    dma_host_bus_master_hold_responder #(
        .HLDA_DELAY (HLDA_DELAY)
    ) u_hold (
        .clk       (CLK),
        .rst       (RESET),
        .hrq       (HRQ),
        .start     (HRQ && (cyc_q == IDLE)),
        .state     (hr_state),
        .active    (hr_active),
        .hlda      (HLDA),
        .bus_owned (bus_owned)
    );

    // HRQ wins over a pending command in IDLE.
    assign ready = (cyc_q == IDLE) && !hr_active && !HRQ && !RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cyc_q   <= IDLE;
            scnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            scnt_q  <= scnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        cyc_d   = cyc_q;
        scnt_d  = scnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        case (cyc_q)
            IDLE: begin
                if (cmd.cmd_valid && ready) begin
                    cyc_d   = SETUP;
                    addr_d  = cmd.cmd_addr;
                    wdata_d = cmd.cmd_wdata;
                    write_d = cmd.cmd_write;
                end
            end
            SETUP: begin
                cyc_d  = STROBE;
                scnt_d = '0;
            end
            STROBE: begin
                // Read data is captured on the edge that ends the strobe.
                if (scnt_q == S_LAST) begin
                    cyc_d = RECOVER;
                    if (!write_q) rdata_d = DB;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            RECOVER: cyc_d = IDLE;
            default: cyc_d = IDLE;
        endcase
    end

    assign in_cycle  = (cyc_q == SETUP) || (cyc_q == STROBE) || (cyc_q == RECOVER);
    assign ior_n_int = !((cyc_q == STROBE) && !write_q);
    assign iow_n_int = !((cyc_q == STROBE) && write_q);

    assign CS_N          = !in_cycle;
    assign cmd.cmd_ready = ready;
    assign cmd.rsp_valid = (cyc_q == RECOVER) && !write_q;
    assign cmd.rsp_rdata = rdata_q;
    assign state         = hr_active ? hr_state : cyc_q;

    assign IOR_N = bus_owned ? ior_n_int : 1'bz;
    assign IOW_N = bus_owned ? iow_n_int : 1'bz;
    assign A0    = bus_owned ? addr_q[0] : 1'bz;
    assign A1    = bus_owned ? addr_q[1] : 1'bz;
    assign A2    = bus_owned ? addr_q[2] : 1'bz;
    assign A3    = bus_owned ? addr_q[3] : 1'bz;
    assign DB    = (bus_owned && in_cycle && write_q) ? wdata_q : {DATAWIDTH{1'bz}};

endmodule

// File: tb/tb_dma_host_bus_master.sv
// Directed bench for the host bus master; plays the CPU on the command port
// and the DMA controller on the shared bus lines.
module tb_dma_host_bus_master;
  import dma_host_bus_master_pkg::*;

  localparam int SC = 2;
  localparam int HD = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hrq;
  logic        HLDA;
  logic        CS_N;
  wire         IOR_N, IOW_N, A0, A1, A2, A3;
  wire  [7:0]  DB;
  host_state_t dbg_state;
  wire  [3:0]  a_bus = {A3, A2, A1, A0};

  // controller-side drivers for the shared lines
  logic       tb_ctl_en, tb_ior_n, tb_iow_n;
  logic [3:0] tb_a;
  logic       tb_db_en;
  logic [7:0] tb_db;
  assign IOR_N = tb_ctl_en ? tb_ior_n : 1'bz;
  assign IOW_N = tb_ctl_en ? tb_iow_n : 1'bz;
  assign A0    = tb_ctl_en ? tb_a[0]  : 1'bz;
  assign A1    = tb_ctl_en ? tb_a[1]  : 1'bz;
  assign A2    = tb_ctl_en ? tb_a[2]  : 1'bz;
  assign A3    = tb_ctl_en ? tb_a[3]  : 1'bz;
  assign DB    = tb_db_en  ? tb_db    : 8'bzzzzzzzz;

  dma_host_bus_master_if cmd_if ();

  dma_host_bus_master #(
    .STROBE_CYCLES (SC),
    .HLDA_DELAY    (HD)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .cmd   (cmd_if),
    .HRQ   (hrq),
    .HLDA  (HLDA),
    .CS_N  (CS_N),
    .IOR_N (IOR_N),
    .IOW_N (IOW_N),
    .A0    (A0),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .DB    (DB),
    .state (dbg_state)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && cmd_if.rsp_valid) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("rsp_rdata", 32'(cmd_if.rsp_rdata), 32'(exp_q.pop_front()));
    end
  end

  // driver: one full I/O cycle starting from IDLE; optionally raises HRQ at step hrq_at
  task automatic do_cycle(input logic wr, input logic [3:0] addr, input logic [7:0] data,
                          input int hrq_at);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = wr;
    cmd_if.cmd_addr  = addr;
    cmd_if.cmd_wdata = wr ? data : ~data;
    if (!wr) begin
      tb_db    = data;
      tb_db_en = 1'b1;
      exp_q.push_back(data);
    end
    #1;
    chk("cmd_ready_idle", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < SC + 2; i++) begin
      chk("cs_n_cycle", 32'(CS_N), 32'd0);
      chk("ior_n_cycle", 32'(IOR_N), 32'(!(!wr && i >= 1 && i <= SC)));
      chk("iow_n_cycle", 32'(IOW_N), 32'(!(wr && i >= 1 && i <= SC)));
      chk("addr_cycle", 32'(a_bus), 32'(addr));
      chk("db_cycle", 32'(DB), 32'(data));
      chk("rsp_valid_cycle", 32'(cmd_if.rsp_valid), 32'(!wr && i == SC + 1));
      if (i == hrq_at) hrq = 1'b1;
      tick();
    end
    tb_db_en = 1'b0;
    #1;
    chk("cs_n_idle", 32'(CS_N), 32'd1);
    chk("state_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    rst = 1'b1;
    hrq = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_write = 1'b0;
    cmd_if.cmd_addr  = 4'h0;
    cmd_if.cmd_wdata = 8'h00;
    tb_ctl_en = 1'b0; tb_ior_n = 1'b1; tb_iow_n = 1'b1; tb_a = 4'h0;
    tb_db_en  = 1'b0; tb_db = 8'h00;

    // reset values
    #7;
    chk("rst_hlda", 32'(HLDA), 32'd0);
    chk("rst_cs_n", 32'(CS_N), 32'd1);
    chk("rst_ior_n", 32'(IOR_N), 32'd1);
    chk("rst_iow_n", 32'(IOW_N), 32'd1);
    chk("rst_addr", 32'(a_bus), 32'd0);
    chk("rst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(cmd_if.rsp_rdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    tb_db = 8'h5A; tb_db_en = 1'b1;
    #1;
    chk("rst_db_released", 32'(DB), 32'h5A);
    tb_db_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(cmd_if.cmd_ready), 32'd1);

    // plain write, read, then a write that must not disturb rsp_rdata
    do_cycle(1'b1, REG_MODE, 8'hA5, -1);
    do_cycle(1'b0, REG_STATUS, 8'h3C, -1);
    do_cycle(1'b1, REG_REQUEST, 8'h04, -1);
    chk("rsp_rdata_hold", 32'(cmd_if.rsp_rdata), 32'h3C);

    // HRQ during STROBE of a write: cycle completes, then hold handover
    do_cycle(1'b1, REG_MODE, 8'hA5, 1);
    chk("hrq_blocks_ready", 32'(cmd_if.cmd_ready), 32'd0);
    chk("hlda_not_yet", 32'(HLDA), 32'd0);
    for (int k = 1; k <= 1 + HD; k++) begin
      tick();
      chk("hlda_latency", 32'(HLDA), 32'(k == 1 + HD));
    end
    chk("state_hold", 32'(dbg_state), 32'(HOLD));
    tb_ctl_en = 1'b1; tb_a = 4'h5; tb_ior_n = 1'b0; tb_iow_n = 1'b0;
    tb_db = 8'h96; tb_db_en = 1'b1;
    #1;
    chk("hold_addr_released", 32'(a_bus), 32'h5);
    chk("hold_ior_released", 32'(IOR_N), 32'd0);
    chk("hold_iow_released", 32'(IOW_N), 32'd0);
    chk("hold_db_released", 32'(DB), 32'h96);
    chk("hold_cs_n", 32'(CS_N), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = 1'b1;
    cmd_if.cmd_addr  = ch_addr_reg(2'd2);
    cmd_if.cmd_wdata = 8'h11;
    #1;
    chk("hold_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    chk("hold_stays", 32'(HLDA), 32'd1);
    chk("hold_no_accept", 32'(CS_N), 32'd1);
    hrq = 1'b0;
    tick();
    chk("turn_hlda_low", 32'(HLDA), 32'd0);
    chk("turn_state", 32'(dbg_state), 32'(TURN));
    chk("turn_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    chk("turn_addr_released", 32'(a_bus), 32'h5);
    chk("turn_ior_released", 32'(IOR_N), 32'd0);
    tick();
    tb_ctl_en = 1'b0; tb_db_en = 1'b0;
    #1;
    chk("redrive_addr", 32'(a_bus), 32'(REG_MODE));
    chk("redrive_ior", 32'(IOR_N), 32'd1);
    chk("redrive_iow", 32'(IOW_N), 32'd1);
    do_cycle(1'b1, ch_addr_reg(2'd2), 8'h11, -1);

    // one-cycle HRQ pulse aborts GRANT
    hrq = 1'b1;
    #1;
    chk("pulse_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
    tick();
    hrq = 1'b0;
    #1;
    chk("pulse_grant", 32'(dbg_state), 32'(GRANT));
    chk("pulse_hlda_grant", 32'(HLDA), 32'd0);
    tick();
    chk("pulse_abort_state", 32'(dbg_state), 32'(IDLE));
    chk("pulse_abort_hlda", 32'(HLDA), 32'd0);
    chk("pulse_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
    tick();
    chk("pulse_hlda_stays", 32'(HLDA), 32'd0);
    do_cycle(1'b0, REG_STATUS, 8'hC3, -1);

    // reset during a read strobe
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_write = 1'b0;
    cmd_if.cmd_addr  = REG_STATUS;
    cmd_if.cmd_wdata = 8'h00;
    tb_db = 8'h77; tb_db_en = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    tick();
    #1;
    chk("rd_strobe_ior", 32'(IOR_N), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ior", 32'(IOR_N), 32'd1);
    chk("rst_mid_cs_n", 32'(CS_N), 32'd1);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mid_rsp", 32'(cmd_if.rsp_valid), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tb_db_en = 1'b0;
    tick();
    #1;
    chk("rst_mid_rdata", 32'(cmd_if.rsp_rdata), 32'd0);
    do_cycle(1'b1, ch_addr_reg(2'd0), 8'h5E, -1);

    // reset while in HOLD drops HLDA at once and re-drives the lines
    hrq = 1'b1;
    for (int k = 0; k < 1 + HD; k++) tick();
    chk("hold2_hlda", 32'(HLDA), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_hold_hlda", 32'(HLDA), 32'd0);
    chk("rst_hold_ior", 32'(IOR_N), 32'd1);
    chk("rst_hold_addr", 32'(a_bus), 32'd0);
    hrq = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
